// File: rtl/tx_bf_pkg.sv
// Shared state encoding and default widths for the transmit beamformer channel.
package tx_bf_pkg;

    localparam int DEF_ADDR_WD = 7;
    localparam int DEF_DLY_WD  = 12;
    localparam int DEF_CYC_WD  = 4;
    localparam int DEF_HP_WD   = 6;

    // Shortest half-cycle the pulser is ever driven for; half_per=0 is promoted to this.
    localparam int HP_MIN = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DELAY,
        ST_POS,
        ST_NEG,
        ST_FIN
    } tx_state_e;

endpackage

// File: rtl/tx_dly_lut.sv
// Read-first single-write/single-read delay RAM with a registered read port.
// Usable for any per-line lookup sitting beside a beamformer channel.
module tx_dly_lut #(
    parameter int AW = 7,
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [0:(2**AW)-1];
    logic [DW-1:0] rd_data_q;

    // Non-blocking update of both ports gives old data on a same-address collision.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/tx_bf_ch.sv
// Single-channel transmit beamformer: per-line focusing delay from a LUT, then a bipolar burst.
// Build option TX_APOD_EN: lut_din gains a mute MSB that suppresses the pulser (binary apodization).
module tx_bf_ch
    import tx_bf_pkg::*;
#(
    parameter int ADDR_WD = DEF_ADDR_WD,
    parameter int DLY_WD  = DEF_DLY_WD,
    parameter int CYC_WD  = DEF_CYC_WD,
    parameter int HP_WD   = DEF_HP_WD
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tx_trig,
    input  logic               abort,
    input  logic [ADDR_WD-1:0] line_addr,
    input  logic [ADDR_WD-1:0] lut_addr,
    input  logic               lut_we,
`ifdef TX_APOD_EN
    input  logic [DLY_WD:0]    lut_din,
`else
    input  logic [DLY_WD-1:0]  lut_din,
`endif
    input  logic [CYC_WD-1:0]  num_cyc,
    input  logic [HP_WD-1:0]   half_per,
    output logic               tx_p,
    output logic               tx_n,
    output logic               tx_busy,
    output logic               tx_done,
    output logic               trig_err
);

    // state | meaning
    // IDLE  | waiting for tx_trig; LUT read issued on accept
    // FETCH | LUT data arrives, delay counter loaded
    // DELAY | counting the focusing delay down to zero
    // POS   | tx_p driven for one half-cycle
    // NEG   | tx_n driven for one half-cycle, burst cycle consumed
    // FIN   | tx_done strobe, back to IDLE

`ifdef TX_APOD_EN
    localparam int LUT_WD = DLY_WD + 1;
`else
    localparam int LUT_WD = DLY_WD;
`endif

    tx_state_e         state_q;
    logic [DLY_WD-1:0] dly_cnt_q;
    logic [HP_WD-1:0]  hp_q;
    logic [HP_WD-1:0]  hp_cnt_q;
    logic [CYC_WD-1:0] cyc_cnt_q;
    logic              tx_p_q;
    logic              tx_n_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic [LUT_WD-1:0] lut_rdata;
    logic              accept_d;
    logic              fire_d;
    logic [HP_WD-1:0]  hp_eff_d;

    assign accept_d = (state_q == ST_IDLE) && tx_trig;
    assign hp_eff_d = (half_per < HP_WD'(HP_MIN)) ? HP_WD'(HP_MIN) : half_per;

    tx_dly_lut #(
        .AW (ADDR_WD),
        .DW (LUT_WD)
    ) u_lut (
        .clk       (clk),
        .wr_en_i   (lut_we),
        .wr_addr_i (lut_addr),
        .wr_data_i (lut_din),
        .rd_en_i   (accept_d),
        .rd_addr_i (line_addr),
        .rd_data_o (lut_rdata)
    );

`ifdef TX_APOD_EN
    logic mute_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mute_q <= 1'b0;
        end else if (state_q == ST_FETCH) begin
            mute_q <= lut_rdata[DLY_WD];
        end
    end

    assign fire_d = ~mute_q;
`else
    assign fire_d = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            dly_cnt_q <= '0;
            hp_q      <= '0;
            hp_cnt_q  <= '0;
            cyc_cnt_q <= '0;
            tx_p_q    <= 1'b0;
            tx_n_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (abort && (state_q != ST_IDLE)) begin
                // Abort wins over a coincident trigger, so no trig_err here.
                state_q <= ST_IDLE;
                tx_p_q  <= 1'b0;
                tx_n_q  <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                if (tx_trig && (state_q != ST_IDLE)) begin
                    err_q <= 1'b1;
                end
                case (state_q)
                    ST_IDLE: begin
                        if (tx_trig) begin
                            state_q   <= ST_FETCH;
                            busy_q    <= 1'b1;
                            cyc_cnt_q <= num_cyc;
                            hp_q      <= hp_eff_d;
                        end
                    end
                    ST_FETCH: begin
                        dly_cnt_q <= lut_rdata[DLY_WD-1:0];
                        if (cyc_cnt_q == '0) begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_DELAY;
                        end
                    end
                    ST_DELAY: begin
                        if (dly_cnt_q == '0) begin
                            state_q  <= ST_POS;
                            hp_cnt_q <= hp_q;
                            tx_p_q   <= fire_d;
                        end else begin
                            dly_cnt_q <= dly_cnt_q - 1'b1;
                        end
                    end
                    ST_POS: begin
                        if (hp_cnt_q == HP_WD'(1)) begin
                            state_q  <= ST_NEG;
                            hp_cnt_q <= hp_q;
                            tx_p_q   <= 1'b0;
                            tx_n_q   <= fire_d;
                        end else begin
                            hp_cnt_q <= hp_cnt_q - 1'b1;
                        end
                    end
                    ST_NEG: begin
                        if (hp_cnt_q == HP_WD'(1)) begin
                            tx_n_q    <= 1'b0;
                            cyc_cnt_q <= cyc_cnt_q - 1'b1;
                            if (cyc_cnt_q == CYC_WD'(1)) begin
                                state_q <= ST_FIN;
                                done_q  <= 1'b1;
                            end else begin
                                state_q  <= ST_POS;
                                hp_cnt_q <= hp_q;
                                tx_p_q   <= fire_d;
                            end
                        end else begin
                            hp_cnt_q <= hp_cnt_q - 1'b1;
                        end
                    end
                    ST_FIN: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        tx_p_q  <= 1'b0;
                        tx_n_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx_p     = tx_p_q;
    assign tx_n     = tx_n_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;
    assign trig_err = err_q;

endmodule
